// File: rtl/event_processor_array.sv
// event_processor_array: multi-channel token event processor.
// Each channel accumulates signed good/bad token increments into saturating
// counters, raises a token when both thresholds are met, holds it for a
// programmable number of timer ticks, then re-arms.
// Optional feature macro: EVENT_PROCESSOR_REFRACTORY_EN adds a REFRACT state
// after ON, during which the channel ignores tokens for another duration.
module event_processor_array #(
    parameter int NUM_CHANNELS    = 2,
    parameter int NEW_TOKENS_BITS = 4,
    parameter int TOKENS_BITS     = 6,
    parameter int DURATION_BITS   = 4
) (
    input  logic                                    clock_fast,
    input  logic                                    reset,
    input  logic                                    tick_en,
    input  logic [NUM_CHANNELS*NEW_TOKENS_BITS-1:0] new_good_tokens,
    input  logic [NUM_CHANNELS*NEW_TOKENS_BITS-1:0] new_bad_tokens,
    input  logic [NUM_CHANNELS*(TOKENS_BITS-1)-1:0] good_tokens_threshold,
    input  logic [NUM_CHANNELS*(TOKENS_BITS-1)-1:0] bad_tokens_threshold,
    input  logic [NUM_CHANNELS*DURATION_BITS-1:0]   duration,
    output logic [NUM_CHANNELS-1:0]                 token_start,
    output logic [NUM_CHANNELS-1:0]                 token_end,
    output logic [NUM_CHANNELS-1:0]                 is_on
);

    localparam int NB = NEW_TOKENS_BITS;
    localparam int TB = TOKENS_BITS;
    localparam int DB = DURATION_BITS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ON      = 2'd1
`ifdef EVENT_PROCESSOR_REFRACTORY_EN
        , ST_REFRACT = 2'd2
`endif
    } state_t;

    // Saturating add of a sign-extended increment; one extra bit exposes overflow
    function automatic logic signed [TB-1:0] satAdd(
        input logic signed [TB-1:0] cnt,
        input logic signed [NB-1:0] inc
    );
        logic signed [TB:0] sum;
        sum = {cnt[TB-1], cnt} + {{(TB + 1 - NB){inc[NB-1]}}, inc};
        if (sum[TB] != sum[TB-1]) begin
            satAdd = sum[TB] ? {1'b1, {(TB - 1){1'b0}}} : {1'b0, {(TB - 1){1'b1}}};
        end else begin
            satAdd = sum[TB-1:0];
        end
    endfunction

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        logic signed [NB-1:0] w_incGood;
        logic signed [NB-1:0] w_incBad;
        logic        [TB-2:0] w_thrGood;
        logic        [TB-2:0] w_thrBad;
        logic        [DB-1:0] w_duration;
        logic signed [TB-1:0] w_reloadGood;
        logic signed [TB-1:0] w_reloadBad;
        logic signed [TB-1:0] w_sumGood;
        logic signed [TB-1:0] w_sumBad;
        logic                 w_goodMet;
        logic                 w_badMet;
        logic                 w_timerZero;

        state_t               r_state;
        state_t               w_nextState;
        logic        [DB-1:0] r_timer;
        logic        [DB-1:0] w_nextTimer;
        logic signed [TB-1:0] r_goodCnt;
        logic signed [TB-1:0] r_badCnt;
        logic signed [TB-1:0] w_nextGood;
        logic signed [TB-1:0] w_nextBad;
        logic                 r_start;
        logic                 r_end;
        logic                 w_nextStart;
        logic                 w_nextEnd;

        assign w_incGood    = new_good_tokens[g*NB +: NB];
        assign w_incBad     = new_bad_tokens[g*NB +: NB];
        assign w_thrGood    = good_tokens_threshold[g*(TB-1) +: (TB-1)];
        assign w_thrBad     = bad_tokens_threshold[g*(TB-1) +: (TB-1)];
        assign w_duration   = duration[g*DB +: DB];

        assign w_reloadGood = -$signed({1'b0, w_thrGood});
        assign w_reloadBad  = -$signed({1'b0, w_thrBad});
        assign w_sumGood    = satAdd(r_goodCnt, w_incGood);
        assign w_sumBad     = satAdd(r_badCnt, w_incBad);

        assign w_goodMet    = ~r_goodCnt[TB-1];
        assign w_badMet     = r_badCnt[TB-1] | (r_badCnt == '0);
        assign w_timerZero  = (r_timer == '0);

        // Next-state, timer, counter and pulse decisions from the registered counts
        always_comb begin
            w_nextState = r_state;
            w_nextTimer = r_timer;
            w_nextGood  = w_sumGood;
            w_nextBad   = w_sumBad;
            w_nextStart = 1'b0;
            w_nextEnd   = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_goodMet && w_badMet) begin
                        w_nextState = ST_ON;
                        w_nextTimer = w_duration;
                        w_nextStart = 1'b1;
                    end
                end
                ST_ON: begin
                    if (!w_badMet || w_timerZero) begin
                        w_nextEnd  = 1'b1;
                        w_nextGood = w_reloadGood;
                        w_nextBad  = w_reloadBad;
`ifdef EVENT_PROCESSOR_REFRACTORY_EN
                        w_nextState = ST_REFRACT;
                        w_nextTimer = w_duration;
`else
                        w_nextState = ST_IDLE;
`endif
                    end else if (tick_en) begin
                        w_nextTimer = r_timer - DB'(1);
                    end
                end
`ifdef EVENT_PROCESSOR_REFRACTORY_EN
                ST_REFRACT: begin
                    w_nextGood = r_goodCnt;
                    w_nextBad  = r_badCnt;
                    if (w_timerZero) begin
                        w_nextState = ST_IDLE;
                    end else if (tick_en) begin
                        w_nextTimer = r_timer - DB'(1);
                    end
                end
`endif
                default: begin
                    w_nextState = ST_IDLE;
                end
            endcase
        end

        // Channel state register with synchronous reset to the armed IDLE state
        always_ff @(posedge clock_fast) begin
            if (reset) begin
                r_state   <= ST_IDLE;
                r_timer   <= '0;
                r_goodCnt <= w_reloadGood;
                r_badCnt  <= w_reloadBad;
                r_start   <= 1'b0;
                r_end     <= 1'b0;
            end else begin
                r_state   <= w_nextState;
                r_timer   <= w_nextTimer;
                r_goodCnt <= w_nextGood;
                r_badCnt  <= w_nextBad;
                r_start   <= w_nextStart;
                r_end     <= w_nextEnd;
            end
        end

        assign token_start[g] = r_start;
        assign token_end[g]   = r_end;
        assign is_on[g]       = (r_state == ST_ON);
    end

endmodule

// File: tb/tb_event_processor_array.sv
// tb_event_processor_array: directed scenarios plus randomized traffic for
// event_processor_array, checked every cycle against a behavioural model
// that tracks each channel's counts, mode and remaining on-time as integers.
module tb_event_processor_array;

    localparam int NC = 2;
    localparam int NB = 4;
    localparam int TB = 6;
    localparam int DB = 4;
    localparam int CNT_MAX = (1 << (TB - 1)) - 1;
    localparam int CNT_MIN = -(1 << (TB - 1));
`ifdef EVENT_PROCESSOR_REFRACTORY_EN
    localparam bit REFRACT_EN = 1'b1;
`else
    localparam bit REFRACT_EN = 1'b0;
`endif

    logic                   clock_fast = 1'b0;
    logic                   reset;
    logic                   tick_en;
    logic [NC*NB-1:0]       new_good_tokens;
    logic [NC*NB-1:0]       new_bad_tokens;
    logic [NC*(TB-1)-1:0]   good_tokens_threshold;
    logic [NC*(TB-1)-1:0]   bad_tokens_threshold;
    logic [NC*DB-1:0]       duration;
    logic [NC-1:0]          token_start;
    logic [NC-1:0]          token_end;
    logic [NC-1:0]          is_on;

    int testCount = 0;
    int failCount = 0;

    // Model state: mode 0 = idle, 1 = on, 2 = refractory
    int mGood[NC];
    int mBad[NC];
    int mTimer[NC];
    int mMode[NC];
    bit mStart[NC];
    bit mEnd[NC];

    event_processor_array #(
        .NUM_CHANNELS(NC),
        .NEW_TOKENS_BITS(NB),
        .TOKENS_BITS(TB),
        .DURATION_BITS(DB)
    ) dut (
        .clock_fast(clock_fast),
        .reset(reset),
        .tick_en(tick_en),
        .new_good_tokens(new_good_tokens),
        .new_bad_tokens(new_bad_tokens),
        .good_tokens_threshold(good_tokens_threshold),
        .bad_tokens_threshold(bad_tokens_threshold),
        .duration(duration),
        .token_start(token_start),
        .token_end(token_end),
        .is_on(is_on)
    );

    always #5 clock_fast = ~clock_fast;

    function automatic int clampCnt(input int v);
        if (v > CNT_MAX) return CNT_MAX;
        if (v < CNT_MIN) return CNT_MIN;
        return v;
    endfunction

    function automatic int incOf(input logic [NC*NB-1:0] vec, input int ch);
        logic signed [NB-1:0] s;
        s = vec[ch*NB +: NB];
        return int'(s);
    endfunction

    function automatic int thrOf(input logic [NC*(TB-1)-1:0] vec, input int ch);
        return int'(vec[ch*(TB-1) +: (TB-1)]);
    endfunction

    function automatic int durOf(input logic [NC*DB-1:0] vec, input int ch);
        return int'(vec[ch*DB +: DB]);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    // Advance the model by one clock edge using the inputs held across that edge
    task automatic modelStep();
        for (int i = 0; i < NC; i++) begin
            int thG;
            int thB;
            int dur;
            int nextGood;
            int nextBad;
            bit rearm;
            bit freeze;
            thG = thrOf(good_tokens_threshold, i);
            thB = thrOf(bad_tokens_threshold, i);
            dur = durOf(duration, i);
            if (reset) begin
                mGood[i] = -thG;
                mBad[i] = -thB;
                mMode[i] = 0;
                mTimer[i] = 0;
                mStart[i] = 1'b0;
                mEnd[i] = 1'b0;
            end else begin
                nextGood = clampCnt(mGood[i] + incOf(new_good_tokens, i));
                nextBad = clampCnt(mBad[i] + incOf(new_bad_tokens, i));
                rearm = 1'b0;
                freeze = 1'b0;
                mStart[i] = 1'b0;
                mEnd[i] = 1'b0;
                if (mMode[i] == 0) begin
                    if (mGood[i] >= 0 && mBad[i] <= 0) begin
                        mMode[i] = 1;
                        mTimer[i] = dur;
                        mStart[i] = 1'b1;
                    end
                end else if (mMode[i] == 1) begin
                    if (mBad[i] > 0 || mTimer[i] == 0) begin
                        mEnd[i] = 1'b1;
                        rearm = 1'b1;
                        if (REFRACT_EN) begin
                            mMode[i] = 2;
                            mTimer[i] = dur;
                        end else begin
                            mMode[i] = 0;
                        end
                    end else if (tick_en && mTimer[i] > 0) begin
                        mTimer[i]--;
                    end
                end else begin
                    freeze = 1'b1;
                    if (mTimer[i] == 0) mMode[i] = 0;
                    else if (tick_en) mTimer[i]--;
                end
                if (rearm) begin
                    mGood[i] = -thG;
                    mBad[i] = -thB;
                end else if (!freeze) begin
                    mGood[i] = nextGood;
                    mBad[i] = nextBad;
                end
            end
        end
    endtask

    task automatic compareModel();
        logic [NC-1:0] eS;
        logic [NC-1:0] eE;
        logic [NC-1:0] eO;
        for (int i = 0; i < NC; i++) begin
            eS[i] = mStart[i];
            eE[i] = mEnd[i];
            eO[i] = (mMode[i] == 1);
        end
        checkOutput("token_start", 32'(token_start), 32'(eS));
        checkOutput("token_end", 32'(token_end), 32'(eE));
        checkOutput("is_on", 32'(is_on), 32'(eO));
    endtask

    task automatic runCycle();
        @(posedge clock_fast);
        modelStep();
        @(negedge clock_fast);
        compareModel();
    endtask

    task automatic setInc(input int ch, input int g, input int b);
        new_good_tokens[ch*NB +: NB] = NB'(g);
        new_bad_tokens[ch*NB +: NB] = NB'(b);
    endtask

    task automatic setThr(input int ch, input int g, input int b);
        good_tokens_threshold[ch*(TB-1) +: (TB-1)] = (TB-1)'(g);
        bad_tokens_threshold[ch*(TB-1) +: (TB-1)] = (TB-1)'(b);
    endtask

    task automatic setDur(input int ch, input int d);
        duration[ch*DB +: DB] = DB'(d);
    endtask

    task automatic doReset();
        reset = 1'b1;
        runCycle();
        runCycle();
        reset = 1'b0;
    endtask

    // Random inputs biased so that channels actually fire, time out and abort
    task automatic applyStimulus();
        tick_en = ($urandom_range(0, 3) != 0);
        reset = ($urandom_range(0, 59) == 0);
        for (int ch = 0; ch < NC; ch++) begin
            int g;
            int b;
            g = int'($urandom_range(0, 10)) - 3;
            b = int'($urandom_range(0, 9)) - 5;
            if ($urandom_range(0, 7) == 0) g = int'($urandom_range(0, 15)) - 8;
            if ($urandom_range(0, 7) == 0) b = int'($urandom_range(0, 15)) - 8;
            setInc(ch, g, b);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 4) == 0) setThr(ch, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
                else setThr(ch, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
            end
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 3) == 0) setDur(ch, int'($urandom_range(0, 15)));
                else setDur(ch, int'($urandom_range(0, 4)));
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        tick_en = 1'b1;
        new_good_tokens = '0;
        new_bad_tokens = '0;
        good_tokens_threshold = '0;
        bad_tokens_threshold = '0;
        duration = '0;

        // Reset state and start latency
        setThr(0, 3, 3);
        setThr(1, 31, 31);
        setDur(0, 4);
        setDur(1, 4);
        doReset();
        checkOutput("resetOutputs", 32'({token_start, token_end, is_on}), 32'd0);
        runCycle();
        setInc(0, 3, 0);
        runCycle();
        checkOutput("preStart", 32'(token_start[0]), 32'd0);
        setInc(0, 0, 0);
        runCycle();
        checkOutput("startLatency", 32'(token_start[0]), 32'd1);
        checkOutput("isOnAfterStart", 32'(is_on[0]), 32'd1);

        // Timeout with duration 4 and tick held high
        for (int k = 0; k < 4; k++) begin
            runCycle();
            checkOutput("timeoutEarly", 32'(token_end[0]), 32'd0);
        end
        runCycle();
        checkOutput("timeoutEnd", 32'(token_end[0]), 32'd1);
        checkOutput("timeoutOff", 32'(is_on[0]), 32'd0);
        runCycle();
        runCycle();
        checkOutput("noRestartAfterReload", 32'(is_on[0]), 32'd0);

        // Bad-token abort on channel 0 while channel 1 times out independently
        setThr(1, 2, 2);
        setDur(0, 15);
        setDur(1, 3);
        doReset();
        setInc(0, 3, 0);
        setInc(1, 2, 0);
        runCycle();
        setInc(0, 0, 0);
        setInc(1, 0, 0);
        runCycle();
        checkOutput("ch0Start", 32'(token_start[0]), 32'd1);
        checkOutput("ch1Start", 32'(token_start[1]), 32'd1);
        setInc(0, 0, 4);
        runCycle();
        checkOutput("abortEarly", 32'(token_end[0]), 32'd0);
        setInc(0, 0, 0);
        runCycle();
        checkOutput("abortEnd", 32'(token_end[0]), 32'd1);
        checkOutput("ch1Independent", 32'(is_on[1]), 32'd1);
        for (int k = 0; k < 4; k++) runCycle();

        // Duration zero: end immediately follows start
        setDur(0, 0);
        doReset();
        setInc(0, 3, 0);
        runCycle();
        setInc(0, 0, 0);
        runCycle();
        checkOutput("dur0Start", 32'(token_start[0]), 32'd1);
        runCycle();
        checkOutput("dur0End", 32'(token_end[0]), 32'd1);
        checkOutput("dur0NoOverlap", 32'(token_start[0]), 32'd0);

        // Reset in the middle of ON aborts without an end pulse
        setDur(0, 15);
        doReset();
        setInc(0, 3, 0);
        runCycle();
        setInc(0, 0, 0);
        runCycle();
        runCycle();
        reset = 1'b1;
        runCycle();
        checkOutput("resetMidOn", 32'(is_on[0]), 32'd0);
        checkOutput("resetNoEnd", 32'(token_end[0]), 32'd0);
        runCycle();
        reset = 1'b0;

        // Saturation: good counter clamps at the top and does not wrap
        tick_en = 1'b0;
        setThr(0, 31, 0);
        doReset();
        setInc(0, 0, 1);
        runCycle();
        setInc(0, 7, 0);
        for (int k = 0; k < 20; k++) runCycle();
        setInc(0, -8, 0);
        runCycle();
        runCycle();
        runCycle();
        setInc(0, -8, -1);
        runCycle();
        setInc(0, 0, 0);
        runCycle();
        checkOutput("satNoWrap", 32'(token_start[0]), 32'd0);
        setInc(0, 1, 0);
        runCycle();
        setInc(0, 0, 0);
        runCycle();
        checkOutput("satRecover", 32'(token_start[0]), 32'd1);

        // Randomized traffic on all channels
        tick_en = 1'b1;
        setThr(0, 2, 2);
        setThr(1, 3, 2);
        setDur(0, 2);
        setDur(1, 1);
        doReset();
        for (int k = 0; k < 1000; k++) begin
            applyStimulus();
            runCycle();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/event_processor_array.md
Name: event_processor_array

Overview:
Multi-channel, single-clock successor of the token event processor core. Each of NUM_CHANNELS independent channels accumulates signed good/bad token increments into saturating counters and raises a token when the good and bad thresholds are met. It holds that token for a programmable number of timer ticks, then re-arms. It sits between the token input fabric and the top-level pin wrapper; timing comes from a tick enable, so no second clock domain and no handshake are needed.

Parameters:
NUM_CHANNELS, 2, number of independent channels
NEW_TOKENS_BITS, 4, width of each signed per-cycle token increment
TOKENS_BITS, 6, width of each signed token counter
DURATION_BITS, 4, width of the on-duration and timer

Ports:
clock_fast  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
tick_en  in  1  timer tick; qualifies every timer decrement
new_good_tokens  in  NUM_CHANNELS*NEW_TOKENS_BITS  signed increment per channel; channel i occupies slice i
new_bad_tokens  in  NUM_CHANNELS*NEW_TOKENS_BITS  signed increment per channel
good_tokens_threshold  in  NUM_CHANNELS*(TOKENS_BITS-1)  unsigned threshold per channel
bad_tokens_threshold  in  NUM_CHANNELS*(TOKENS_BITS-1)  unsigned threshold per channel
duration  in  NUM_CHANNELS*DURATION_BITS  on-time in ticks per channel
token_start  out  NUM_CHANNELS  one-cycle pulse when a channel turns on
token_end  out  NUM_CHANNELS  one-cycle pulse when a channel turns off
is_on  out  NUM_CHANNELS  level; channel is in state ON

Behaviour:
- Reset, while reset=1 on any edge:
  - good_cnt[i] = -good_threshold[i]; bad_cnt[i] = -bad_threshold[i].
  - Each threshold is zero-extended to TOKENS_BITS before negation.
  - State = IDLE, timer = 0, and all outputs are 0.
  - Reset mid-ON aborts the channel with no token_end pulse.
- Accumulation, every non-reset edge:
  - cnt <= sat(cnt + sign_extend(inc)).
  - Saturation limits are -2^(TOKENS_BITS-1) and 2^(TOKENS_BITS-1)-1; the counter never wraps.
- Per-channel FSM, decisions taken from registered counts:
  - IDLE -> ON when good_cnt>=0 and bad_cnt<=0.
    - On that edge: timer <= duration[i], token_start=1, is_on=1.
  - ON, decrement: if tick_en=1 and timer!=0, timer <= timer-1.
  - ON -> IDLE when bad_cnt>0, or when timer==0 is seen at a clock edge.
    - On that edge: token_end=1, is_on=0.
    - The channel re-arms: both counters are reloaded to their negated thresholds.
    - The reload overrides that cycle's increments; those increments are discarded.
  - Both off conditions true at once produce a single token_end.
- Latency:
  - An increment sampled at edge E is in the counter after edge E.
  - token_start is visible after edge E+1 (2-cycle input-to-pulse latency).
- Boundary cases:
  - duration=0: token_end follows token_start by exactly 1 cycle.
  - token_start and token_end are never both 1 in the same cycle for one channel.
  - Channels are fully independent; simultaneous events on different channels are all served in the same cycle.
  - Threshold and duration inputs are sampled only at reset, at re-arm (thresholds) and on IDLE->ON (duration).

Optional Feature:
Macro: EVENT_PROCESSOR_REFRACTORY_EN.
- When defined: ON -> REFRACT instead of IDLE.
  - On entry the timer is reloaded with duration[i] and decrements on tick_en.
  - REFRACT -> IDLE when timer==0.
  - In REFRACT the counters hold at their reloaded values and increments are discarded.
  - setOn is ignored in REFRACT; is_on=0.
- When undefined: the REFRACT state does not exist and ON returns directly to IDLE.

Test Plan:
1. Reset: thresholds 3/3 on channel 0 -> good_cnt=-3, bad_cnt=-3, all outputs 0. Then good +3 for one cycle -> token_start[0] 2 cycles after the increment; is_on[0]=1.
2. Timeout: duration=4, tick_en held high -> token_end[0] 5 cycles after token_start[0]; counters reloaded to -3/-3.
3. Bad abort: channel 0 ON, duration=15, bad +4 -> token_end 2 cycles later, timer ignored. Channel 1 runs concurrently, unaffected.
4. Saturation: TOKENS_BITS=6, good +7 every cycle for 20 cycles -> good_cnt holds at 31. Then -8 -> 23; no wrap.
5. Corner cases: duration=0 -> start and end pulses on consecutive cycles. Reset asserted mid-ON -> is_on=0 next edge, no token_end.
6. With EVENT_PROCESSOR_REFRACTORY_EN, duration=2: after token_end, good +3 during REFRACT produces no start. A new start occurs only after 2 ticks plus fresh tokens.
